// File: rtl/voice_scheduler.sv
// voice_scheduler: time-multiplexes one wavetable ROM across NUM_VOICES voices and mixes one sample per period.
// Optional feature macro VOICE_SCHED_PHASE_RESET_EN: an accepted frequency write also clears that voice's phase.
module voice_scheduler #(
    parameter int NUM_VOICES = 8,
    parameter int PHASE_W    = 32,
    parameter int FREQ_W     = 16,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int ENV_W      = 8,
    parameter int SAMPLE_DIV = 501
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
    input  logic                          cfg_sel,
    input  logic [FREQ_W-1:0]             cfg_data,
    output logic [ADDR_W-1:0]             rom_addr,
    input  logic [DATA_W-1:0]             rom_data,
    output logic                          busy,
    output logic [DATA_W-1:0]             mix_out,
    output logic                          mix_valid
);
    localparam int VW    = $clog2(NUM_VOICES);
    localparam int ACC_W = DATA_W + ENV_W + VW;
    localparam int CNT_W = $clog2(SAMPLE_DIV);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, OUT} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [VW-1:0]             k_q, k_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [ADDR_W-1:0]         rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]         mix_q, mix_d;
    logic [PHASE_W-1:0]        phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]        phase_d [NUM_VOICES];
    logic [FREQ_W-1:0]         freq_q  [NUM_VOICES];
    logic [FREQ_W-1:0]         freq_d  [NUM_VOICES];
    logic [ENV_W-1:0]          env_q   [NUM_VOICES];
    logic [ENV_W-1:0]          env_d   [NUM_VOICES];
    logic [DATA_W+ENV_W-1:0]   prod;
    logic [VW-1:0]             acc_v;
    logic                      tick, wr, acc_en;

    assign tick      = cnt_q == CNT_W'(SAMPLE_DIV - 1);
    assign busy      = state_q == SCAN || state_q == DRAIN;
    assign cfg_ready = !busy;
    assign wr        = cfg_valid && cfg_ready;
    assign mix_valid = state_q == OUT;
    assign mix_out   = mix_q;
    assign rom_addr  = rom_addr_q;
    // ROM data arriving now belongs to the voice addressed one cycle earlier
    assign acc_en    = (state_q == SCAN && k_q != '0) || state_q == DRAIN;
    assign acc_v     = k_q - VW'(1);
    assign prod      = {{ENV_W{1'b0}}, rom_data} * {{DATA_W{1'b0}}, env_q[acc_v]};

    // Free-running sample-period divider
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) cnt_q <= '0;
        else         cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Config writes, scan sequencing, phase stepping and accumulation
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        acc_d      = acc_q;
        mix_d      = mix_q;
        rom_addr_d = rom_addr_q;
        phase_d    = phase_q;
        freq_d     = freq_q;
        env_d      = env_q;
        if (wr) begin
            if (cfg_sel) env_d[cfg_voice] = cfg_data[ENV_W-1:0];
            else begin
                freq_d[cfg_voice] = cfg_data;
`ifdef VOICE_SCHED_PHASE_RESET_EN
                phase_d[cfg_voice] = '0;
`endif
            end
        end
        if (acc_en) acc_d = acc_q + {{VW{1'b0}}, prod};
        case (state_q)
            IDLE: if (tick) begin
                state_d    = SCAN;
                k_d        = '0;
                acc_d      = '0;
                rom_addr_d = phase_d[0][PHASE_W-1 -: ADDR_W];
            end
            SCAN: begin
                phase_d[k_q] = phase_q[k_q] + PHASE_W'(freq_q[k_q]);
                k_d          = k_q + VW'(1);
                if (k_q == VW'(NUM_VOICES - 1)) state_d = DRAIN;
                else rom_addr_d = phase_q[k_q + VW'(1)][PHASE_W-1 -: ADDR_W];
            end
            DRAIN: begin
                state_d = OUT;
                mix_d   = acc_d[ACC_W-1 -: DATA_W];
            end
            OUT: state_d = IDLE;
        endcase
    end

    // State and per-voice register file; reset aborts any scan in flight
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            acc_q      <= '0;
            mix_q      <= '0;
            rom_addr_q <= '0;
            phase_q    <= '{default: '0};
            freq_q     <= '{default: '0};
            env_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            mix_q      <= mix_d;
            rom_addr_q <= rom_addr_d;
            phase_q    <= phase_d;
            freq_q     <= freq_d;
            env_q      <= env_d;
        end
    end

    // A tick outside IDLE would drop a sample period; SAMPLE_DIV >= NUM_VOICES+3 rules it out
    assert property (@(posedge clk) disable iff (!nreset) tick |-> state_q == IDLE);
endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler: directed and random scans checked against a per-sample arithmetic model.
module tb_voice_scheduler;
    localparam int N  = 8;
    localparam int PW = 16;
    localparam int FW = 16;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int EW = 8;
    localparam int SD = 24;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_sel = 1'b0;
    logic [2:0]    cfg_voice = '0;
    logic [FW-1:0] cfg_data = '0;
    logic          cfg_ready, busy, mix_valid;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data, mix_out;

    int passed = 0, total = 0, fails = 0;
    int e = 0, mode = 1, last_mix = 0;
    int ph [N], fr [N], env [N], got [N];
    int tab [256];
    int wrap_exp [5] = '{0, 64, 128, 192, 0};

    voice_scheduler #(
        .NUM_VOICES(N), .PHASE_W(PW), .FREQ_W(FW), .ADDR_W(AW),
        .DATA_W(DW), .ENV_W(EW), .SAMPLE_DIV(SD)
    ) dut (
        .clk(clk), .nreset(nreset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_voice(cfg_voice), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy),
        .mix_out(mix_out), .mix_valid(mix_valid)
    );

    always #5 clk = ~clk;

    function automatic int romf(input int a);
        return mode == 0 ? a : mode == 1 ? 255 : tab[a];
    endfunction

    always @(posedge clk) rom_data <= DW'(romf(int'(rom_addr)));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic wait_tick();
        while (e % SD != SD - 1) step();
    endtask

    task automatic apply(input int v, input int sel, input int d);
        if (sel != 0) env[v] = d & 255;
        else begin
            fr[v] = d & 16'hffff;
`ifdef VOICE_SCHED_PHASE_RESET_EN
            ph[v] = 0;
`endif
        end
    endtask

    task automatic drive(input int v, input int sel, input int d);
        cfg_valid = 1'b1;
        cfg_voice = 3'(v);
        cfg_sel   = sel[0];
        cfg_data  = FW'(d);
    endtask

    task automatic wr(input int v, input int sel, input int d);
        check("idle_cfg_ready", cfg_ready, 1);
        drive(v, sel, d);
        step();
        cfg_valid = 1'b0;
        apply(v, sel, d);
    endtask

    task automatic reset_model();
        for (int v = 0; v < N; v++) begin
            ph[v] = 0; fr[v] = 0; env[v] = 0;
        end
    endtask

    task automatic do_scan(input bit bp, input int bv, input int bd);
        int addr [N];
        longint sum;
        int exp_mix;
        check("tick_busy", busy, 0);
        sum = 0;
        for (int v = 0; v < N; v++) begin
            addr[v] = (ph[v] >> 8) & 255;
            sum += longint'(romf(addr[v]) * env[v]);
            ph[v] = (ph[v] + fr[v]) & 16'hffff;
        end
        exp_mix = int'(sum >> 11);
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k > 0) step();
            if (bp && k == 2) drive(bv, 0, bd);
            got[k] = int'(rom_addr);
            check("scan_rom_addr", rom_addr, addr[k]);
            check("scan_busy", busy, 1);
            check("scan_cfg_ready", cfg_ready, 0);
            check("scan_mix_valid", mix_valid, 0);
        end
        step();
        check("drain_busy", busy, 1);
        check("drain_cfg_ready", cfg_ready, 0);
        check("drain_mix_valid", mix_valid, 0);
        step();
        check("out_mix_valid", mix_valid, 1);
        check("out_mix", mix_out, exp_mix);
        check("out_busy", busy, 0);
        check("out_cfg_ready", cfg_ready, 1);
        last_mix = exp_mix;
        step();
        cfg_valid = 1'b0;
        if (bp) apply(bv, 0, bd);
        check("post_mix_valid", mix_valid, 0);
        check("mix_hold", mix_out, exp_mix);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tab[i] = int'($urandom_range(0, 255));
        reset_model();
        repeat (5) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        @(negedge clk);
        nreset = 1'b1;
        e = 0;
        check("rel_cfg_ready", cfg_ready, 1);
        check("rel_busy", busy, 0);
        check("rel_mix_valid", mix_valid, 0);
        check("rel_mix_out", mix_out, 0);
        check("rel_rom_addr", rom_addr, 0);

        // first sample with all envelopes zero
        mode = 1;
        wait_tick();
        check("first_tick_edge", e, SD - 1);
        do_scan(0, 0, 0);
        check("first_mix_zero", mix_out, 0);

        // phase wrap on voice 0
        wr(0, 0, 16'h4000);
        for (int i = 0; i < 5; i++) begin
            wait_tick();
            do_scan(0, 0, 0);
            check("wrap_addr_v0", got[0], wrap_exp[i]);
        end

        // full-scale mix, then half the voices muted
        for (int v = 0; v < N; v++) wr(v, 1, 255);
        wait_tick();
        do_scan(0, 0, 0);
        check("full_mix", mix_out, 254);
        for (int v = 0; v < 4; v++) wr(v, 1, 0);
        wait_tick();
        do_scan(0, 0, 0);
        check("half_mix", mix_out, 127);

        // ROM echoes address: scan order and distinct frequencies
        mode = 0;
        for (int v = 0; v < N; v++) wr(v, 0, int'($urandom & 32'hfff8) | v);
        wait_tick();
        do_scan(0, 0, 0);
        for (int v = 0; v < N; v++) wr(v, 1, int'($urandom_range(0, 255)));
        wait_tick();
        do_scan(0, 0, 0);
        wait_tick();
        do_scan(0, 0, 0);

        // random table, random writes, tick-cycle writes and backpressure
        mode = 2;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++)
                wr(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 1)), int'($urandom & 32'hffff));
            wait_tick();
            if ($urandom_range(0, 1) == 1) begin
                int v, s, d;
                v = int'($urandom_range(0, N - 1));
                s = int'($urandom_range(0, 1));
                d = int'($urandom & 32'hffff);
                drive(v, s, d);
                apply(v, s, d);
            end
            do_scan(i % 2 == 1, int'($urandom_range(0, N - 1)), int'($urandom & 32'hffff));
        end

        // reset in the middle of a scan
        wait_tick();
        repeat (4) step();
        nreset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_rom_addr", rom_addr, 0);
        check("abort_mix_valid", mix_valid, 0);
        check("abort_mix_out", mix_out, 0);
        check("abort_cfg_ready", cfg_ready, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
        e = 0;
        reset_model();
        while (e % SD != SD - 1) begin
            check("abort_no_mix_valid", mix_valid, 0);
            step();
        end
        check("abort_tick_edge", e, SD - 1);
        do_scan(0, 0, 0);

        // frequency change on voice 2 mid-note
        wr(2, 0, 16'h1000);
        for (int i = 0; i < 3; i++) begin
            wait_tick();
            do_scan(0, 0, 0);
        end
        wr(2, 0, 16'h2000);
        wait_tick();
        do_scan(0, 0, 0);
`ifdef VOICE_SCHED_PHASE_RESET_EN
        check("v2_hard_sync", got[2], 0);
`else
        check("v2_continuous", got[2], 16'h30);
`endif
        wait_tick();
        do_scan(0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
